// File: rtl/weight_stream_loader.sv
// Streams weight words into a shadow bank for the masked MACs (ascending index order),
// then copies the masked shadow entries into the registered active bank on commit.
module weight_stream_loader #(
  parameter int N_MACS = 4,
  parameter int WPM    = 2,
  parameter int DW     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_MACS-1:0]          weight_ctrl_i,
  input  logic                       busy_i,
  input  logic                       w_valid_i,
  input  logic [DW-1:0]              w_data_i,
  output logic                       w_ready_o,
  input  logic                       commit_i,
  output logic [N_MACS*WPM*DW-1:0]   weights_out_o,
  output logic [N_MACS-1:0]          weights_vld_o,
  output logic                       load_done_o,
  output logic                       load_abort_o
);

  localparam int WW = (WPM > 1) ? $clog2(WPM) : 1;
  localparam int MW = (N_MACS > 1) ? $clog2(N_MACS) : 1;
  localparam int BW = N_MACS * WPM * DW;
  localparam int MB = WPM * DW;

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t              state_q, state_d;
  logic [N_MACS-1:0]   ctrl_q;
  logic [N_MACS-1:0]   mask_q, mask_d;
  logic [MW-1:0]       ptr_q, ptr_d;
  logic [WW-1:0]       word_q, word_d;
  logic [BW-1:0]       shadow_q, shadow_d;
  logic [BW-1:0]       active_q, active_d;
  logic [N_MACS-1:0]   vld_q, vld_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;

  logic                trigger;
  logic [MW-1:0]       first_ptr;
  logic [MW-1:0]       nxt_ptr;
  logic                nxt_found;

  assign trigger = (weight_ctrl_i != '0) && (weight_ctrl_i != ctrl_q);

  // Descending scans so the lowest qualifying index is the one left standing.
  always_comb begin
    first_ptr = '0;
    nxt_ptr   = ptr_q;
    nxt_found = 1'b0;
    for (int i = N_MACS - 1; i >= 0; i--) begin
      if (weight_ctrl_i[i]) begin
        first_ptr = MW'(i);
      end
      if (mask_q[i] && (i > int'(ptr_q))) begin
        nxt_ptr   = MW'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    word_d    = word_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    vld_d     = vld_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    w_ready_o = (state_q == FILL);

    case (state_q)
      IDLE: begin
        if (trigger) begin
          mask_d  = weight_ctrl_i;
          ptr_d   = first_ptr;
          word_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (!busy_i && !commit_i) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (w_valid_i) begin
          shadow_d[(int'(ptr_q) * WPM + int'(word_q)) * DW +: DW] = w_data_i;
          if (word_q == WW'(WPM - 1)) begin
            word_d = '0;
            if (nxt_found) begin
              ptr_d = nxt_ptr;
            end else begin
              state_d = FULL;
              done_d  = 1'b1;
            end
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end
      FULL: begin
        // Commit wins over a simultaneous busy drop.
        if (commit_i) begin
          for (int m = 0; m < N_MACS; m++) begin
            if (mask_q[m]) begin
              active_d[m*MB +: MB] = shadow_q[m*MB +: MB];
              vld_d[m]             = 1'b1;
            end
          end
          state_d = IDLE;
        end else if (!busy_i) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      mask_q   <= '0;
      ptr_q    <= '0;
      word_q   <= '0;
      shadow_q <= '0;
      active_q <= '0;
      vld_q    <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= weight_ctrl_i;
      mask_q   <= mask_d;
      ptr_q    <= ptr_d;
      word_q   <= word_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  assign weights_out_o = active_q;
  assign weights_vld_o = vld_q;
  assign load_done_o   = done_q;
  assign load_abort_o  = abort_q;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed table-driven bench for weight_stream_loader (N_MACS=4, WPM=2, DW=8).
module tb_weight_stream_loader;

  logic        clk;
  logic        rst;
  logic [3:0]  weight_ctrl;
  logic        busy;
  logic        w_valid;
  logic [7:0]  w_data;
  logic        w_ready;
  logic        commit;
  logic [63:0] weights_out;
  logic [3:0]  weights_vld;
  logic        load_done;
  logic        load_abort;

  int checks = 0;
  int errors = 0;

  weight_stream_loader #(.N_MACS(4), .WPM(2), .DW(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .weight_ctrl_i (weight_ctrl),
    .busy_i        (busy),
    .w_valid_i     (w_valid),
    .w_data_i      (w_data),
    .w_ready_o     (w_ready),
    .commit_i      (commit),
    .weights_out_o (weights_out),
    .weights_vld_o (weights_vld),
    .load_done_o   (load_done),
    .load_abort_o  (load_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic        busy;
    logic        valid;
    logic [7:0]  data;
    logic        commit;
    logic        rdy;
    logic        done;
    logic        abort;
    logic [3:0]  vld;
    logic [63:0] wout;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] W1 = 64'h0000_0000_2221_1211;
  localparam logic [63:0] W2 = 64'hA3A2_A1A0_2221_1211;
  localparam logic [63:0] W3 = 64'hA3A2_A1A0_4241_3231;
  localparam logic [63:0] W5 = 64'h6463_A1A0_4241_6261;

  task automatic add(input logic [3:0] c, input logic b, input logic v, input logic [7:0] d,
                     input logic cm, input logic r, input logic dn, input logic ab,
                     input logic [3:0] vl, input logic [63:0] wo);
    vec_t t;
    t.ctrl = c; t.busy = b; t.valid = v; t.data = d; t.commit = cm;
    t.rdy = r; t.done = dn; t.abort = ab; t.vld = vl; t.wout = wo;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic r, input logic dn,
                           input logic ab, input logic [3:0] vl, input logic [63:0] wo);
    check({tag, ".w_ready"}, idx, 64'(w_ready), 64'(r));
    check({tag, ".load_done"}, idx, 64'(load_done), 64'(dn));
    check({tag, ".load_abort"}, idx, 64'(load_abort), 64'(ab));
    check({tag, ".weights_vld"}, idx, 64'(weights_vld), 64'(vl));
    check({tag, ".weights_out"}, idx, weights_out, wo);
  endtask

  initial begin
    rst = 1'b1; weight_ctrl = '0; busy = 1'b0; w_valid = 1'b0; w_data = '0; commit = 1'b0;

    // Basic load, mask 0011
    add(4'h3,1,0,8'h00,0, 1,0,0,4'h0,64'h0);
    add(4'h3,1,1,8'h11,0, 1,0,0,4'h0,64'h0);
    add(4'h3,1,1,8'h12,0, 1,0,0,4'h0,64'h0);
    add(4'h3,1,1,8'h21,0, 1,0,0,4'h0,64'h0);
    add(4'h3,1,1,8'h22,0, 0,1,0,4'h0,64'h0);
    add(4'h3,1,0,8'h00,1, 0,0,0,4'h3,W1);
    // Layer mask 1100
    add(4'hC,1,0,8'h00,0, 1,0,0,4'h3,W1);
    add(4'hC,1,1,8'hA0,0, 1,0,0,4'h3,W1);
    add(4'hC,1,1,8'hA1,0, 1,0,0,4'h3,W1);
    add(4'hC,1,1,8'hA2,0, 1,0,0,4'h3,W1);
    add(4'hC,1,1,8'hA3,0, 0,1,0,4'h3,W1);
    add(4'hC,1,0,8'h00,1, 0,0,0,4'hF,W2);
    // Gaps, commit ignored in FILL, extra beats refused in FULL
    add(4'h3,1,0,8'h00,0, 1,0,0,4'hF,W2);
    add(4'h3,1,0,8'h00,1, 1,0,0,4'hF,W2);
    add(4'h3,1,1,8'h31,0, 1,0,0,4'hF,W2);
    add(4'h3,1,0,8'h99,0, 1,0,0,4'hF,W2);
    add(4'h3,1,1,8'h32,0, 1,0,0,4'hF,W2);
    add(4'h3,1,1,8'h41,0, 1,0,0,4'hF,W2);
    add(4'h3,1,0,8'h77,0, 1,0,0,4'hF,W2);
    add(4'h3,1,1,8'h42,0, 0,1,0,4'hF,W2);
    add(4'h3,1,1,8'hFF,0, 0,0,0,4'hF,W2);
    add(4'h3,1,1,8'hEE,1, 0,0,0,4'hF,W3);
    // Abort after two beats, later commit has no effect
    add(4'h6,1,0,8'h00,0, 1,0,0,4'hF,W3);
    add(4'h6,1,1,8'h51,0, 1,0,0,4'hF,W3);
    add(4'h6,1,1,8'h52,0, 1,0,0,4'hF,W3);
    add(4'h6,0,0,8'h00,0, 0,0,1,4'hF,W3);
    add(4'h6,1,0,8'h00,1, 0,0,0,4'hF,W3);
    // Sparse mask 1001, mask change mid-fill ignored, commit beats abort
    add(4'h9,1,0,8'h00,0, 1,0,0,4'hF,W3);
    add(4'h9,1,1,8'h61,0, 1,0,0,4'hF,W3);
    add(4'h1,1,1,8'h62,0, 1,0,0,4'hF,W3);
    add(4'h1,1,1,8'h63,0, 1,0,0,4'hF,W3);
    add(4'h1,1,1,8'h64,0, 0,1,0,4'hF,W3);
    add(4'h1,0,0,8'h00,1, 0,0,0,4'hF,W5);
    add(4'h1,1,0,8'h00,0, 0,0,0,4'hF,W5);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      weight_ctrl = vecs[i].ctrl;
      busy        = vecs[i].busy;
      w_valid     = vecs[i].valid;
      w_data      = vecs[i].data;
      commit      = vecs[i].commit;
      @(posedge clk);
      #1;
      check_all("vec", i, vecs[i].rdy, vecs[i].done, vecs[i].abort, vecs[i].vld, vecs[i].wout);
    end

    // Reset mid-fill: outputs clear asynchronously, no abort pulse afterwards
    weight_ctrl = 4'h8; busy = 1'b1; w_valid = 1'b0; commit = 1'b0;
    @(posedge clk); #1;
    check("rst_seq.fill_ready", 0, 64'(w_ready), 64'h1);
    w_valid = 1'b1; w_data = 8'h71;
    @(posedge clk); #1;
    w_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all("rst_seq.async", 1, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    weight_ctrl = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_seq.no_abort", 2 + k, 64'(load_abort), 64'h0);
      check("rst_seq.wout", 2 + k, weights_out, 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
